// File: rtl/seg7_frame_reader.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus and assembles
// one DIGITS-wide frame per complete in-order scan.
module seg7_frame_reader #(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   frame_data,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  frame_valid,
    output logic                  busy
);

    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {SYNC, COLLECT, DONE} state_t;

    state_t                state, state_d;
    logic [6:0]            s_seg;
    logic [DIGITS-1:0]     s_an;
    logic [CW-1:0]         cnt;
    logic                  captured;
    logic                  in_diff;
    logic                  capture;
    logic [IW-1:0]         dig_idx;
    logic [IW-1:0]         expect_idx, expect_d;
    logic [3:0]            nib;
    logic                  seg_err;
    logic                  store_en;
    logic                  publish;
    logic [4*DIGITS-1:0]   shadow_nib;
    logic [DIGITS-1:0]     shadow_err;

    assign in_diff = (seg_n != s_seg) || (an_n != s_an);
    assign capture = (cnt == CNT_MAX) && !captured && $onehot(~s_an);

    // Sampling stage and stability counter; a change of input re-arms capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg    <= '1;
            s_an     <= '1;
            cnt      <= '0;
            captured <= 1'b0;
        end else begin
            s_seg <= seg_n;
            s_an  <= an_n;
            if (in_diff) begin
                cnt      <= '0;
                captured <= 1'b0;
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                if (capture) captured <= 1'b1;
            end
        end
    end

    always_comb begin
        dig_idx = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!s_an[i]) dig_idx = IW'(i);
        end
    end

    // Active-low segment pattern (g..a) to hex nibble.
    always_comb begin
        nib     = 4'h0;
        seg_err = 1'b0;
        case (s_seg)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0011000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default:    seg_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= SYNC;
        else     state <= state_d;
    end

    // Frame sequencing; out-of-order digits abandon the frame, digit 0 restarts it.
    always_comb begin
        state_d  = state;
        expect_d = expect_idx;
        store_en = 1'b0;
        publish  = 1'b0;
        case (state)
            SYNC: begin
                if (capture && dig_idx == '0) begin
                    store_en = 1'b1;
                    expect_d = IW'(1);
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (capture) begin
                    if (dig_idx == expect_idx) begin
                        store_en = 1'b1;
                        expect_d = expect_idx + IW'(1);
                        if (dig_idx == LAST_IDX) state_d = DONE;
                    end else if (dig_idx == '0) begin
                        store_en = 1'b1;
                        expect_d = IW'(1);
                    end else begin
                        state_d = SYNC;
                    end
                end
            end
            DONE: begin
                publish = 1'b1;
                state_d = SYNC;
                if (capture && dig_idx == '0) begin
                    store_en = 1'b1;
                    expect_d = IW'(1);
                    state_d  = COLLECT;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            expect_idx  <= '0;
            shadow_nib  <= '0;
            shadow_err  <= '0;
            frame_data  <= '0;
            err_mask    <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            expect_idx  <= expect_d;
            frame_valid <= publish;
            busy        <= (state_d != SYNC);
            if (publish) begin
                frame_data <= shadow_nib;
                err_mask   <= shadow_err;
            end
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (store_en && dig_idx == IW'(i)) begin
                    shadow_nib[4*i +: 4] <= nib;
                    shadow_err[i]        <= seg_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Directed scans of the 7-segment bus; a monitor checks each frame_valid against a queue.
module tb_seg7_frame_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic [31:0] frame_data;
    logic [7:0]  err_mask;
    logic        frame_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    frame_t exp_q[$];
    logic prev_fv = 1'b0;

    logic [6:0] seg_of [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seg7_frame_reader #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_data  (frame_data),
        .err_mask    (err_mask),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [7:0] e);
        frame_t f;
        f.data = d;
        f.err  = e;
        exp_q.push_back(f);
    endtask

    // Called at a negedge; the values are seen by exactly n rising edges.
    task automatic hold(input logic [6:0] s, input logic [7:0] a, input int n);
        seg_n = s;
        an_n  = a;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] w, input logic [7:0] blank,
                        input int first, input int last, input int h);
        logic [6:0] s;
        for (int d = first; d <= last; d++) begin
            s = blank[d] ? 7'h7F : seg_of[w[4*d +: 4]];
            hold(s, ~(8'b1 << d), h);
        end
    endtask

    // Scoreboard monitor
    initial begin
        frame_t e;
        forever begin
            @(negedge clk);
            if (frame_valid) begin
                check("fv_pulse", 32'(prev_fv), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: frame_valid with data %h err %h, none expected",
                             frame_data, err_mask);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", frame_data, e.data);
                    check("sb_err", 32'(err_mask), 32'(e.err));
                end
            end
            prev_fv = frame_valid;
        end
    end

    initial begin
        rst   = 1'b1;
        seg_n = '1;
        an_n  = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_data", frame_data, 32'h0);
        check("rst_err", 32'(err_mask), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // 1: digits show 1..8, latency and busy window
        push_exp(32'h8765_4321, 8'h00);
        scan(32'h8765_4321, 8'h00, 0, 0, 6);
        check("busy_after_d0", 32'(busy), 32'h1);
        scan(32'h8765_4321, 8'h00, 1, 6, 6);
        check("busy_mid", 32'(busy), 32'h1);
        scan(32'h8765_4321, 8'h00, 7, 7, 6);
        check("lat_fv", 32'(frame_valid), 32'h1);
        check("busy_end", 32'(busy), 32'h0);

        // 2: letters
        push_exp(32'h10FE_DCBA, 8'h00);
        scan(32'h10FE_DCBA, 8'h00, 0, 7, 6);

        // 3: blank digit 2 decodes as 0 with error flag
        push_exp(32'h8765_4021, 8'h04);
        scan(32'h8765_4321, 8'h04, 0, 7, 6);

        // 4: short digit 3 abandons the frame
        scan(32'h1111_1111, 8'h00, 0, 2, 6);
        scan(32'h1111_1111, 8'h00, 3, 3, 3);
        scan(32'h1111_1111, 8'h00, 4, 4, 6);
        check("abandon_busy", 32'(busy), 32'h0);
        push_exp(32'h2468_ACE0, 8'h00);
        scan(32'h2468_ACE0, 8'h00, 0, 7, 6);
        // multi-hot and zero-hot selects mid-frame leave the frame intact
        push_exp(32'h9753_1FDB, 8'h00);
        scan(32'h9753_1FDB, 8'h00, 0, 3, 6);
        hold(seg_of[5], 8'b1111_1100, 10);
        check("multihot_busy", 32'(busy), 32'h1);
        hold(seg_of[5], 8'b1111_1111, 10);
        scan(32'h9753_1FDB, 8'h00, 4, 7, 6);

        // 5: reset mid-frame clears outputs and discards the partial frame
        scan(32'h5555_5555, 8'h00, 0, 4, 6);
        rst  = 1'b1;
        an_n = '1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_data", frame_data, 32'h0);
        check("rst2_err", 32'(err_mask), 32'h0);
        check("rst2_busy", 32'(busy), 32'h0);
        scan(32'h5555_5555, 8'h00, 5, 7, 6);
        check("resume_busy", 32'(busy), 32'h0);
        push_exp(32'h0123_4567, 8'h00);
        scan(32'h0123_4567, 8'h00, 0, 7, 6);

        // 6: long digit 0 hold, then two back-to-back scans
        push_exp(32'hCAFE_F00D, 8'h00);
        scan(32'hCAFE_F00D, 8'h00, 0, 0, 40);
        scan(32'hCAFE_F00D, 8'h00, 1, 7, 6);
        push_exp(32'h3141_5926, 8'h00);
        push_exp(32'h0BAD_BEEF, 8'h80);
        scan(32'h3141_5926, 8'h00, 0, 7, 6);
        scan(32'hFBAD_BEEF, 8'h80, 0, 7, 6);

        hold(7'h7F, 8'hFF, 12);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
